// File: rtl/i2c_target_regs.sv
// I2C target responder with an 8-bit register pointer and byte write strobes.
//
// The target answers a single 7-bit address. It never drives SCL, so there is no clock stretching.
// The first data byte of a write transaction loads the register pointer.
// Each later data byte is issued on wr_stb at the pointer, and the pointer then post-increments.
// A read shifts out rd_data at the pointer. The pointer advances on every master ACK.
//
// Ports:
//   clk48    - 48 MHz system clock; SCL/SDA are sampled in this domain
//   reset_n  - asynchronous active-low reset
//   scl_in   - raw SCL pad input
//   sda_in   - raw SDA pad input
//   sda_oe   - 1 pulls SDA low, 0 releases it (open drain)
//   busy     - high while addressed, from the address ACK until STOP/START/NACK
//   wr_stb   - one-cycle pulse: write wr_data to register wr_addr
//   wr_addr  - register index of the write
//   wr_data  - write data byte
//   rd_addr  - current register pointer
//   rd_data  - register bank contents at rd_addr (combinational)
module i2c_target_regs #(
  parameter logic [6:0]  ADDRESS    = 7'h25,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk48,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck
  } state_e;

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning. Bit 0 carries SCL and bit 1 carries SDA.
  // ---------------------------------------------------------------------------
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic [1:0] r_filt_q;
  logic [1:0] w_filt;

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= 2'b11;
      r_sync   <= 2'b11;
      r_filt_q <= 2'b11;
    end else begin
      r_meta   <= {sda_in, scl_in};
      r_sync   <= r_meta;
      r_filt_q <= w_filt;
    end
  end

  // The filtered level follows the synchronised input only after FILTER_LEN
  // consecutive samples that differ from the current filtered level.
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic [CntW-1:0] r_cnt;
    logic            r_lvl;

    always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b1;
      end else if (r_sync[g] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_cnt <= '0;
        r_lvl <= r_sync[g];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_filt[g] = r_lvl;
  end

  logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  assign w_scl_rise = w_filt[0] & ~r_filt_q[0];
  assign w_scl_fall = ~w_filt[0] & r_filt_q[0];
  assign w_sda_rise = w_filt[1] & ~r_filt_q[1];
  assign w_sda_fall = ~w_filt[1] & r_filt_q[1];
  assign w_start    = w_sda_fall & w_filt[0];
  assign w_stop     = w_sda_rise & w_filt[0];

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_e     r_state, w_state_d;
  logic [2:0] r_cnt, w_cnt_d;
  logic [7:0] r_shift, w_shift_d;
  logic [7:0] r_ptr, w_ptr_d;
  logic       r_first, w_first_d;
  logic       r_rw, w_rw_d;
  // In an ACK state: the ACK is being driven. In StRdAck: the master has ACKed.
  logic       r_ack_drv, w_ack_drv_d;
  logic       r_sda_oe, w_sda_oe_d;
  logic       r_busy, w_busy_d;
  logic       r_wr_stb, w_wr_stb_d;
  logic [7:0] r_wr_addr, w_wr_addr_d;
  logic [7:0] r_wr_data, w_wr_data_d;
  logic [7:0] w_byte;

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_cnt     <= 3'd0;
      r_shift   <= 8'h00;
      r_ptr     <= 8'h00;
      r_first   <= 1'b0;
      r_rw      <= 1'b0;
      r_ack_drv <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 8'h00;
      r_wr_data <= 8'h00;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_shift   <= w_shift_d;
      r_ptr     <= w_ptr_d;
      r_first   <= w_first_d;
      r_rw      <= w_rw_d;
      r_ack_drv <= w_ack_drv_d;
      r_sda_oe  <= w_sda_oe_d;
      r_busy    <= w_busy_d;
      r_wr_stb  <= w_wr_stb_d;
      r_wr_addr <= w_wr_addr_d;
      r_wr_data <= w_wr_data_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_shift_d   = r_shift;
    w_ptr_d     = r_ptr;
    w_first_d   = r_first;
    w_rw_d      = r_rw;
    w_ack_drv_d = r_ack_drv;
    w_sda_oe_d  = r_sda_oe;
    w_busy_d    = r_busy;
    w_wr_stb_d  = 1'b0;
    w_wr_addr_d = r_wr_addr;
    w_wr_data_d = r_wr_data;
    // The byte as it stands once the bit sampled on this rise is included.
    w_byte      = {r_shift[6:0], w_filt[1]};

    if (w_start) begin
      // A partial byte is dropped. The pointer survives a repeated START.
      w_state_d   = StAddr;
      w_cnt_d     = 3'd0;
      w_ack_drv_d = 1'b0;
      w_sda_oe_d  = 1'b0;
      w_busy_d    = 1'b0;
    end else if (w_stop) begin
      w_state_d   = StIdle;
      w_ack_drv_d = 1'b0;
      w_sda_oe_d  = 1'b0;
      w_busy_d    = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
        end

        StAddr: begin
          if (w_scl_rise) begin
            w_shift_d = w_byte;
            w_cnt_d   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_cnt_d = 3'd0;
              if (w_byte[7:1] == ADDRESS) begin
                w_state_d   = StAddrAck;
                w_rw_d      = w_byte[0];
                w_ack_drv_d = 1'b0;
              end else begin
                w_state_d = StIdle;
              end
            end
          end
        end

        // The first fall drives the ACK. The second fall releases it and
        // starts the data phase.
        StAddrAck, StWrAck: begin
          if (w_scl_fall) begin
            if (!r_ack_drv) begin
              w_sda_oe_d  = 1'b1;
              w_busy_d    = 1'b1;
              w_ack_drv_d = 1'b1;
            end else begin
              w_ack_drv_d = 1'b0;
              w_cnt_d     = 3'd0;
              w_sda_oe_d  = 1'b0;
              if (r_state == StWrAck) begin
                w_state_d = StWrData;
              end else if (r_rw) begin
                w_state_d  = StRdData;
                w_shift_d  = rd_data;
                w_sda_oe_d = ~rd_data[7];
              end else begin
                w_state_d = StWrData;
                w_first_d = 1'b1;
              end
            end
          end
        end

        StWrData: begin
          if (w_scl_rise) begin
            w_shift_d = w_byte;
            w_cnt_d   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_cnt_d     = 3'd0;
              w_state_d   = StWrAck;
              w_ack_drv_d = 1'b0;
              if (r_first) begin
                w_ptr_d   = w_byte;
                w_first_d = 1'b0;
              end else begin
                w_wr_addr_d = r_ptr;
                w_wr_data_d = w_byte;
                w_wr_stb_d  = 1'b1;
                w_ptr_d     = r_ptr + 8'd1;
              end
            end
          end
        end

        StRdData: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd7) begin
              w_cnt_d     = 3'd0;
              w_sda_oe_d  = 1'b0;
              w_ack_drv_d = 1'b0;
              w_state_d   = StRdAck;
            end else begin
              w_shift_d  = {r_shift[6:0], 1'b0};
              w_sda_oe_d = ~r_shift[6];
              w_cnt_d    = r_cnt + 3'd1;
            end
          end
        end

        StRdAck: begin
          if (w_scl_rise) begin
            if (!w_filt[1]) begin
              w_ptr_d     = r_ptr + 8'd1;
              w_ack_drv_d = 1'b1;
            end else begin
              w_state_d = StIdle;
              w_busy_d  = 1'b0;
            end
          end else if (w_scl_fall && r_ack_drv) begin
            // rd_data already reflects the incremented pointer here.
            w_ack_drv_d = 1'b0;
            w_shift_d   = rd_data;
            w_sda_oe_d  = ~rd_data[7];
            w_cnt_d     = 3'd0;
            w_state_d   = StRdData;
          end
        end

        default: begin
          w_state_d  = StIdle;
          w_sda_oe_d = 1'b0;
          w_busy_d   = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe  = r_sda_oe;
  assign busy    = r_busy;
  assign wr_stb  = r_wr_stb;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_ptr;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs. An open-drain I2C master is modelled on the bus.
// The register bank returns rd_addr + 0x30.
module tb_i2c_target_regs;

  localparam int Q = 16;  // clk48 cycles per quarter SCL period

  logic       clk48   = 1'b0;
  logic       reset_n = 1'b0;
  logic       m_scl   = 1'b1;
  logic       m_sda   = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, busy, wr_stb;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] wq_addr[$];
  logic [7:0] wq_data[$];
  bit         oe_seen = 1'b0;

  assign scl_in  = m_scl;
  assign sda_in  = m_sda & ~sda_oe;
  assign rd_data = rd_addr + 8'h30;

  i2c_target_regs #(
    .ADDRESS   (7'h25),
    .FILTER_LEN(3)
  ) dut (
    .clk48  (clk48),
    .reset_n(reset_n),
    .scl_in (scl_in),
    .sda_in (sda_in),
    .sda_oe (sda_oe),
    .busy   (busy),
    .wr_stb (wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #10 clk48 = ~clk48;

  always @(negedge clk48) begin
    if (reset_n && wr_stb) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master primitives ----------------
  task automatic qwait();
    repeat (Q) @(posedge clk48);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b1; qwait();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    qwait();
    m_scl = 1'b1; qwait(); qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    b = sda_in;   qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic master_nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(master_nack);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    #5;
    checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wr_stb !== 1'b0)   begin errors++; $display("FAIL reset_wr_stb got %b want 0", wr_stb); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    checks++; if (rd_addr !== 8'h00) begin errors++; $display("FAIL reset_rd_addr got %h want 00", rd_addr); end
    repeat (3) @(posedge clk48);
    #1 reset_n = 1'b1;
    qwait();
  endtask

  task automatic test_write();
    logic       ack;
    logic [7:0] exp_a[2] = '{8'h10, 8'h11};
    logic [7:0] exp_d[2] = '{8'hAB, 8'hCD};
    logic [7:0] bytes[3] = '{8'h10, 8'hAB, 8'hCD};
    wq_addr.delete(); wq_data.delete();
    i2c_start();
    write_byte(8'h4A, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_addr_ack got %b want 1", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      write_byte(bytes[i], ack);
      checks++;
      if (ack !== 1'b1) begin errors++; $display("FAIL write_data_ack[%0d] got %b want 1", i, ack); end
    end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
    checks++;
    if (wq_addr.size() !== 2) begin
      errors++; $display("FAIL write_stb_count got %0d want 2", wq_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wq_addr[i] !== exp_a[i] || wq_data[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL write_stb[%0d] got (%h,%h) want (%h,%h)", i, wq_addr[i], wq_data[i],
                   exp_a[i], exp_d[i]);
        end
      end
    end
    checks++; if (rd_addr !== 8'h12) begin errors++; $display("FAIL write_ptr got %h want 12", rd_addr); end
  endtask

  task automatic test_read_rs();
    logic       ack;
    logic [7:0] d;
    logic [7:0] exp[3] = '{8'h35, 8'h36, 8'h37};
    i2c_start();
    write_byte(8'h4A, ack);
    write_byte(8'h05, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_ptr_ack got %b want 1", ack); end
    i2c_start();
    write_byte(8'h4B, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_addr_ack got %b want 1", ack); end
    for (int i = 0; i < 3; i++) begin
      read_byte(i == 2, d);
      checks++;
      if (d !== exp[i]) begin errors++; $display("FAIL read_byte[%0d] got %h want %h", i, d, exp[i]); end
    end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL read_release got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_nack got %b want 0", busy); end
    i2c_stop();
    checks++; if (rd_addr !== 8'h07) begin errors++; $display("FAIL read_ptr got %h want 07", rd_addr); end
  endtask

  task automatic test_mismatch();
    logic ack;
    wq_addr.delete(); wq_data.delete();
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h4C, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mismatch_ack got %b want 0", ack); end
    write_byte(8'h00, ack);
    i2c_stop();
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL mismatch_oe got %b want 0", oe_seen); end
    checks++;
    if (wq_addr.size() !== 0) begin
      errors++; $display("FAIL mismatch_stb got %0d want 0", wq_addr.size());
    end
    checks++; if (rd_addr !== 8'h07) begin errors++; $display("FAIL mismatch_ptr got %h want 07", rd_addr); end
  endtask

  task automatic test_wrap();
    logic ack;
    wq_addr.delete(); wq_data.delete();
    i2c_start();
    write_byte(8'h4A, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    i2c_stop();
    checks++;
    if (wq_addr.size() !== 2) begin
      errors++; $display("FAIL wrap_stb_count got %0d want 2", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 8'hFF || wq_data[0] !== 8'h11) begin
        errors++; $display("FAIL wrap_stb0 got (%h,%h) want (ff,11)", wq_addr[0], wq_data[0]);
      end
      checks++;
      if (wq_addr[1] !== 8'h00 || wq_data[1] !== 8'h22) begin
        errors++; $display("FAIL wrap_stb1 got (%h,%h) want (00,22)", wq_addr[1], wq_data[1]);
      end
    end
    checks++; if (rd_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr got %h want 01", rd_addr); end
  endtask

  task automatic test_abort();
    logic ack;
    i2c_start();
    write_byte(8'h4A, ack);
    write_byte(8'h40, ack);
    wq_addr.delete(); wq_data.delete();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    checks++;
    if (wq_addr.size() !== 0) begin
      errors++; $display("FAIL abort_stb got %0d want 0", wq_addr.size());
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (rd_addr !== 8'h40) begin errors++; $display("FAIL abort_ptr got %h want 40", rd_addr); end
    i2c_start();
    write_byte(8'h4A, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL abort_reack got %b want 1", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_rebusy got %b want 1", busy); end
    i2c_stop();
  endtask

  task automatic test_reset_mid();
    logic ack;
    int   n;
    i2c_start();
    write_byte(8'h4A, ack);
    write_byte(8'h20, ack);  // bank returns 0x50: first read bit is 0
    i2c_start();
    write_byte(8'h4B, ack);
    n = 0;
    while (sda_oe !== 1'b1 && n < 4 * Q) begin
      @(posedge clk48);
      n++;
    end
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_drive got %b want 1", sda_oe); end
    @(negedge clk48);
    reset_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_release got %b want 0", sda_oe); end
    checks++; if (rd_addr !== 8'h00) begin errors++; $display("FAIL rstmid_ptr got %h want 00", rd_addr); end
    m_scl = 1'b1;
    m_sda = 1'b1;
    qwait();
    reset_n = 1'b1;
    oe_seen = 1'b0;
    repeat (4) qwait();
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL rstmid_idle_oe got %b want 0", oe_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_rs();
    test_mismatch();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) responder that answers a single 7-bit address, at the other end of the bus from the design's i2c_master.
- Exposes an 8-bit register pointer and byte read/write strobes to an external register bank.
- Used as an on-board test responder and as a host-accessible register port.
- SCL/SDA are sampled in the clk48 domain. The target never drives SCL (no clock stretching).

Parameters:
ADDRESS, 7'h25, 7-bit target address matched in the address byte.
FILTER_LEN, 3, consecutive identical clk48 samples required before a filtered SCL/SDA level changes.

Ports:
clk48  input  1  system clock, 48 MHz
reset_n  input  1  asynchronous active-low reset
scl_in  input  1  raw SCL pad input
sda_in  input  1  raw SDA pad input
sda_oe  output  1  1 = pull SDA low; 0 = release (open drain)
busy  output  1  1 while addressed, from address ACK until STOP/START/NACK-end
wr_stb  output  1  one-cycle pulse: write wr_data to register wr_addr
wr_addr  output  8  register index for the write
wr_data  output  8  write data byte
rd_addr  output  8  current register pointer, presented continuously
rd_data  input  8  external bank contents at rd_addr, combinational from rd_addr

Behaviour:
- Reset (async, reset_n=0) forces these values:
  - state IDLE, pointer 0, sda_oe 0, busy 0, wr_stb 0, wr_addr 0, wr_data 0.
  - Filtered SCL/SDA = 1.
- Input conditioning:
  - 2-flop synchroniser, then a FILTER_LEN stability filter.
  - Edge detects (scl_rise, scl_fall, sda_rise, sda_fall) are single-cycle pulses on the filtered signals.
- Bus conditions:
  - START = sda_fall while filtered SCL=1.
  - STOP = sda_rise while filtered SCL=1.
  - Both are recognised in every state, including mid-byte. START/STOP take precedence over any simultaneous bit event.
- On START: go to ADDR, bit count 0, sda_oe 0, busy 0. The pointer is unchanged, so a repeated START preserves it.
- On STOP: go to IDLE, sda_oe 0, busy 0.
- Data bits are sampled MSB first on scl_rise. sda_oe changes only in the cycle after scl_fall.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits. After the 8th scl_rise, compare bits[7:1] with ADDRESS.
    - Mismatch: go to IDLE with sda_oe 0.
    - Match: go to ADDR_ACK.
  - ADDR_ACK: sda_oe=1 after the next scl_fall, busy=1. Release on the following scl_fall.
    - R/W=0: go to WR_DATA, first_byte=1.
    - R/W=1: go to RD_DATA, and on that same scl_fall load the shift register from rd_data.
  - WR_DATA: shift 8 bits.
    - If first_byte: pointer <= byte, first_byte <= 0.
    - Else: wr_addr <= pointer, wr_data <= byte, wr_stb pulse, then pointer <= pointer+1.
    - Both actions happen on the 8th scl_rise. Go to WR_ACK.
  - WR_ACK: ACK driven exactly as in ADDR_ACK, then return to WR_DATA.
  - RD_DATA: sda_oe = ~shift[7], updated after each scl_fall; shift left on scl_fall.
    - After 8 bits, release SDA on the 8th falling edge and go to RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - 0 (ACK): pointer+1. On the next scl_fall load rd_data at the new pointer and return to RD_DATA.
    - 1 (NACK): go to IDLE (busy 0); wait for STOP/START.
- Pointer arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00.
- Reset mid-transfer releases SDA immediately and asynchronously.
- wr_stb is never asserted outside WR_DATA completion. A write is never issued for a partial byte (STOP or START mid-byte discards it).

Test Plan:
- Write: START, 0x4A(W), 0x10, 0xAB, 0xCD, STOP → three ACKs after the address; wr_stb twice: (0x10,0xAB), (0x11,0xCD); rd_addr=0x12 after.
- Read with repeated START: write pointer 0x05, Sr, 0x4B(R); bank returns reg n = n+0x30; master ACK, ACK, NACK → bytes 0x35, 0x36, 0x37 on SDA; SDA released after NACK; busy 0.
- Mismatch: START, 0x4C(W), 0x00 → sda_oe never 1; no wr_stb; pointer unchanged.
- Wrap: write pointer 0xFF, data 0x11, 0x22 → wr_stb at 0xFF then 0x00.
- Abort: STOP after 4 bits of a data byte → no wr_stb, state IDLE. Then a new START plus a correct address → ACK.
- Reset_n pulsed low while driving a read 0 bit → sda_oe 0 in the same cycle; pointer 0; bus idle thereafter.
